// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
// Holds the PC, takes memory-stage redirects, and drains/freezes on HALT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000,
  parameter logic [15:0] NOP_INSTR   = 16'h0800
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_halt_commit,
  input  logic [15:0] i_imem_rdata,
  output logic [15:0] o_imem_addr,
  output logic [15:0] o_ifid_instr,
  output logic [15:0] o_ifid_pc_plus2,
  output logic        o_ifid_valid,
  output logic        o_halted
);

  typedef enum logic [1:0] {S_RUN, S_HALT_PEND, S_HALTED} state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ifid_instr;
  logic [15:0] r_ifid_pc_plus2;
  logic        r_ifid_valid;
  logic        r_halted;

  logic [15:0] w_pc_plus2;
  logic [15:0] w_redirect_target;
  logic        w_is_halt;

  assign w_pc_plus2        = r_pc + 16'd2;
  assign w_redirect_target = i_redirect_pc & 16'hFFFE;
  assign w_is_halt         = (i_imem_rdata[15:11] == HALT_OPCODE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_RUN;
      r_pc            <= RESET_PC;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc_plus2 <= 16'h0000;
      r_ifid_valid    <= 1'b0;
      r_halted        <= 1'b0;
    end else if (r_state != S_HALTED) begin
      if (i_redirect) begin
        // A redirect while HALT is pending means that HALT was on the wrong path.
        r_state         <= S_RUN;
        r_pc            <= w_redirect_target;
        r_ifid_instr    <= NOP_INSTR;
        r_ifid_pc_plus2 <= 16'h0000;
        r_ifid_valid    <= 1'b0;
      end else if (i_stall) begin
        r_state <= r_state;
      end else if (r_state == S_RUN) begin
        r_ifid_instr    <= i_imem_rdata;
        r_ifid_pc_plus2 <= w_pc_plus2;
        r_ifid_valid    <= 1'b1;
        if (w_is_halt) begin
          r_state <= S_HALT_PEND;
        end else begin
          r_pc <= w_pc_plus2;
        end
      end else begin
        r_ifid_instr    <= NOP_INSTR;
        r_ifid_pc_plus2 <= 16'h0000;
        r_ifid_valid    <= 1'b0;
        if (i_halt_commit) begin
          r_state  <= S_HALTED;
          r_halted <= 1'b1;
        end
      end
    end
  end

  assign o_imem_addr     = r_pc;
  assign o_ifid_instr    = r_ifid_instr;
  assign o_ifid_pc_plus2 = r_ifid_pc_plus2;
  assign o_ifid_valid    = r_ifid_valid;
  assign o_halted        = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage
// Each cycle's stimulus and expected outputs are queued together, then replayed.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt_commit = 1'b0;
  logic [15:0] imem_rdata;
  logic [15:0] imem_addr;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic        hc;
  } stim_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pp2;
    logic        valid;
    logic        halted;
  } exp_t;

  stim_t stq[$];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  string tname;

  always #5 clk = ~clk;

  // Instruction memory: HALT (0x0000) lives at address 8, elsewhere 0x4000+addr.
  assign imem_rdata = (imem_addr == 16'h0008) ? 16'h0000 : (16'h4000 + imem_addr);

  fetch_stage dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stall        (stall),
    .i_redirect     (redirect),
    .i_redirect_pc  (redirect_pc),
    .i_halt_commit  (halt_commit),
    .i_imem_rdata   (imem_rdata),
    .o_imem_addr    (imem_addr),
    .o_ifid_instr   (ifid_instr),
    .o_ifid_pc_plus2(ifid_pc_plus2),
    .o_ifid_valid   (ifid_valid),
    .o_halted       (halted)
  );

  task automatic add(input logic r, input logic st, input logic rd, input logic [15:0] rpc,
                     input logic hc, input logic [15:0] a, input logic [15:0] ins,
                     input logic [15:0] p2, input logic v, input logic h);
    stim_t s;
    exp_t  e;
    s.rst = r; s.stall = st; s.redirect = rd; s.rpc = rpc; s.hc = hc;
    e.addr = a; e.instr = ins; e.pp2 = p2; e.valid = v; e.halted = h;
    stq.push_back(s);
    sb.push_back(e);
  endtask

  task automatic add_reset();
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0800, 16'h0000, 0, 0);
  endtask

  task automatic apply(input stim_t s);
    rst = s.rst; stall = s.stall; redirect = s.redirect;
    redirect_pc = s.rpc; halt_commit = s.hc;
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    tname = "reset_run";
    add_reset();
    add(0, 0, 0, 16'h0, 0, 16'h0002, 16'h4000, 16'h0002, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0004, 16'h4002, 16'h0004, 1, 0);
    add(0, 0, 0, 16'h0, 1, 16'h0006, 16'h4004, 16'h0006, 1, 0);
    for (int c = 0; sb.size() > 0; c++) begin
      s = stq.pop_front(); e = sb.pop_front();
      apply(s); @(posedge clk); #1;
      checks++;
      if (imem_addr !== e.addr || ifid_instr !== e.instr || ifid_pc_plus2 !== e.pp2 ||
          ifid_valid !== e.valid || halted !== e.halted) begin
        errors++;
        $display("FAIL %s cyc %0d: addr %h/%h instr %h/%h pp2 %h/%h valid %b/%b halted %b/%b (got/exp)",
                 tname, c, imem_addr, e.addr, ifid_instr, e.instr, ifid_pc_plus2, e.pp2,
                 ifid_valid, e.valid, halted, e.halted);
      end
    end
  endtask

  task automatic test_stall();
    stim_t s;
    exp_t  e;
    tname = "stall";
    add_reset();
    add(0, 0, 0, 16'h0, 0, 16'h0002, 16'h4000, 16'h0002, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0004, 16'h4002, 16'h0004, 1, 0);
    add(0, 1, 0, 16'h0, 0, 16'h0004, 16'h4002, 16'h0004, 1, 0);
    add(0, 1, 0, 16'h0, 0, 16'h0004, 16'h4002, 16'h0004, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0006, 16'h4004, 16'h0006, 1, 0);
    for (int c = 0; sb.size() > 0; c++) begin
      s = stq.pop_front(); e = sb.pop_front();
      apply(s); @(posedge clk); #1;
      checks++;
      if (imem_addr !== e.addr || ifid_instr !== e.instr || ifid_pc_plus2 !== e.pp2 ||
          ifid_valid !== e.valid || halted !== e.halted) begin
        errors++;
        $display("FAIL %s cyc %0d: addr %h/%h instr %h/%h pp2 %h/%h valid %b/%b halted %b/%b (got/exp)",
                 tname, c, imem_addr, e.addr, ifid_instr, e.instr, ifid_pc_plus2, e.pp2,
                 ifid_valid, e.valid, halted, e.halted);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t s;
    exp_t  e;
    tname = "redirect";
    add_reset();
    add(0, 0, 0, 16'h0, 0, 16'h0002, 16'h4000, 16'h0002, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0004, 16'h4002, 16'h0004, 1, 0);
    add(0, 1, 1, 16'h0101, 0, 16'h0100, 16'h0800, 16'h0000, 0, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0102, 16'h4100, 16'h0102, 1, 0);
    for (int c = 0; sb.size() > 0; c++) begin
      s = stq.pop_front(); e = sb.pop_front();
      apply(s); @(posedge clk); #1;
      checks++;
      if (imem_addr !== e.addr || ifid_instr !== e.instr || ifid_pc_plus2 !== e.pp2 ||
          ifid_valid !== e.valid || halted !== e.halted) begin
        errors++;
        $display("FAIL %s cyc %0d: addr %h/%h instr %h/%h pp2 %h/%h valid %b/%b halted %b/%b (got/exp)",
                 tname, c, imem_addr, e.addr, ifid_instr, e.instr, ifid_pc_plus2, e.pp2,
                 ifid_valid, e.valid, halted, e.halted);
      end
    end
  endtask

  task automatic add_run_to_halt();
    add_reset();
    add(0, 0, 0, 16'h0, 0, 16'h0002, 16'h4000, 16'h0002, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0004, 16'h4002, 16'h0004, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0006, 16'h4004, 16'h0006, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0008, 16'h4006, 16'h0008, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0008, 16'h0000, 16'h000A, 1, 0);
  endtask

  task automatic test_halt();
    stim_t s;
    exp_t  e;
    tname = "halt";
    add_run_to_halt();
    add(0, 1, 0, 16'h0, 0, 16'h0008, 16'h0000, 16'h000A, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0008, 16'h0800, 16'h0000, 0, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0008, 16'h0800, 16'h0000, 0, 0);
    add(0, 0, 0, 16'h0, 1, 16'h0008, 16'h0800, 16'h0000, 0, 1);
    add(0, 1, 1, 16'h0040, 0, 16'h0008, 16'h0800, 16'h0000, 0, 1);
    add(0, 1, 0, 16'h0, 0, 16'h0008, 16'h0800, 16'h0000, 0, 1);
    add(0, 0, 0, 16'h0, 1, 16'h0008, 16'h0800, 16'h0000, 0, 1);
    for (int c = 0; sb.size() > 0; c++) begin
      s = stq.pop_front(); e = sb.pop_front();
      apply(s); @(posedge clk); #1;
      checks++;
      if (imem_addr !== e.addr || ifid_instr !== e.instr || ifid_pc_plus2 !== e.pp2 ||
          ifid_valid !== e.valid || halted !== e.halted) begin
        errors++;
        $display("FAIL %s cyc %0d: addr %h/%h instr %h/%h pp2 %h/%h valid %b/%b halted %b/%b (got/exp)",
                 tname, c, imem_addr, e.addr, ifid_instr, e.instr, ifid_pc_plus2, e.pp2,
                 ifid_valid, e.valid, halted, e.halted);
      end
    end
  endtask

  task automatic test_halt_squash();
    stim_t s;
    exp_t  e;
    tname = "halt_squash";
    add_run_to_halt();
    add(0, 0, 0, 16'h0, 0, 16'h0008, 16'h0800, 16'h0000, 0, 0);
    add(0, 0, 1, 16'h0020, 0, 16'h0020, 16'h0800, 16'h0000, 0, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0022, 16'h4020, 16'h0022, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0024, 16'h4022, 16'h0024, 1, 0);
    add(0, 0, 0, 16'h0, 1, 16'h0026, 16'h4024, 16'h0026, 1, 0);
    for (int c = 0; sb.size() > 0; c++) begin
      s = stq.pop_front(); e = sb.pop_front();
      apply(s); @(posedge clk); #1;
      checks++;
      if (imem_addr !== e.addr || ifid_instr !== e.instr || ifid_pc_plus2 !== e.pp2 ||
          ifid_valid !== e.valid || halted !== e.halted) begin
        errors++;
        $display("FAIL %s cyc %0d: addr %h/%h instr %h/%h pp2 %h/%h valid %b/%b halted %b/%b (got/exp)",
                 tname, c, imem_addr, e.addr, ifid_instr, e.instr, ifid_pc_plus2, e.pp2,
                 ifid_valid, e.valid, halted, e.halted);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    stim_t s;
    exp_t  e;
    tname = "wrap_reset";
    add_reset();
    add(0, 0, 1, 16'hFFFF, 0, 16'hFFFE, 16'h0800, 16'h0000, 0, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0000, 16'h3FFE, 16'h0000, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0002, 16'h4000, 16'h0002, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0004, 16'h4002, 16'h0004, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0006, 16'h4004, 16'h0006, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0008, 16'h4006, 16'h0008, 1, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0008, 16'h0000, 16'h000A, 1, 0);
    add(0, 0, 0, 16'h0, 1, 16'h0008, 16'h0800, 16'h0000, 0, 1);
    add(1, 1, 1, 16'h0040, 1, 16'h0000, 16'h0800, 16'h0000, 0, 0);
    add(0, 0, 0, 16'h0, 0, 16'h0002, 16'h4000, 16'h0002, 1, 0);
    for (int c = 0; sb.size() > 0; c++) begin
      s = stq.pop_front(); e = sb.pop_front();
      apply(s); @(posedge clk); #1;
      checks++;
      if (imem_addr !== e.addr || ifid_instr !== e.instr || ifid_pc_plus2 !== e.pp2 ||
          ifid_valid !== e.valid || halted !== e.halted) begin
        errors++;
        $display("FAIL %s cyc %0d: addr %h/%h instr %h/%h pp2 %h/%h valid %b/%b halted %b/%b (got/exp)",
                 tname, c, imem_addr, e.addr, ifid_instr, e.instr, ifid_pc_plus2, e.pp2,
                 ifid_valid, e.valid, halted, e.halted);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_halt();
    test_halt_squash();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
